// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, wait-state limit and bus width defaults.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_MAX_WAIT   = 15;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_WAIT   = 2'd1,
    APB_ACCESS = 2'd2
  } apb_slv_state_t;

endpackage

// File: rtl/apb_reg_bank.sv
// DEPTH x DATA_WIDTH register array with one write port and one registered read port.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage update and read-data capture; a same-edge read sees the old word.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (we) begin
        mem_r[widx] <= wdata;
      end
      if (re) begin
        rdata_r <= mem_r[ridx];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: SETUP latch, programmable wait states, address decode and a word register bank.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > APB_MAX_WAIT) ? 4'(APB_MAX_WAIT)
                                                                  : 4'(WAIT_CYCLES);
  localparam logic NO_WAIT = (WAIT_INIT == 4'd0);

  apb_slv_state_t        state_r;
  logic [3:0]            cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  hit_r;
  logic                  write_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  ready_r;
  logic                  rd_hit_r;

  logic                  setup_s;
  logic [IDX_W-1:0]      idx_in_s;
  logic                  hit_in_s;
  logic                  to_access_s;
  logic                  we_s;
  logic                  re_s;
  logic [IDX_W-1:0]      ridx_s;
  logic                  rd_hit_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_addr_s;

  assign setup_s       = PSEL & ~PENABLE;
  assign idx_in_s      = PADDR[IDX_W+1:2];
  assign hit_in_s      = (PADDR[ADDR_WIDTH-1:IDX_W+2] == {(ADDR_WIDTH-IDX_W-2){1'b0}});
  assign unused_addr_s = ^PADDR[1:0];

  // Bank strobes; with no wait states the read must use the live SETUP address.
  always_comb begin
    to_access_s = 1'b0;
    we_s        = 1'b0;
    re_s        = 1'b0;
    ridx_s      = idx_r;
    rd_hit_s    = hit_r;
    case (state_r)
      APB_IDLE: begin
        if (setup_s && NO_WAIT) begin
          to_access_s = 1'b1;
          re_s        = ~PWRITE;
          ridx_s      = idx_in_s;
          rd_hit_s    = hit_in_s;
        end else begin
          to_access_s = 1'b0;
        end
      end
      APB_WAIT: begin
        if (PSEL && (cnt_r == 4'd1)) begin
          to_access_s = 1'b1;
          re_s        = ~write_r;
        end else begin
          to_access_s = 1'b0;
        end
      end
      APB_ACCESS: begin
        if (PSEL && PENABLE) begin
          we_s = write_r & hit_r;
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        to_access_s = 1'b0;
      end
    endcase
  end

  // Transfer FSM with registered PREADY and the SETUP-phase latches.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r  <= APB_IDLE;
      cnt_r    <= 4'd0;
      idx_r    <= {IDX_W{1'b0}};
      hit_r    <= 1'b0;
      write_r  <= 1'b0;
      wdata_r  <= {DATA_WIDTH{1'b0}};
      ready_r  <= 1'b0;
      rd_hit_r <= 1'b0;
    end else begin
      if (re_s) begin
        rd_hit_r <= rd_hit_s;
      end
      case (state_r)
        APB_IDLE: begin
          ready_r <= 1'b0;
          if (setup_s) begin
            idx_r   <= idx_in_s;
            hit_r   <= hit_in_s;
            write_r <= PWRITE;
            wdata_r <= PWDATA;
            cnt_r   <= WAIT_INIT;
            if (to_access_s) begin
              state_r <= APB_ACCESS;
              ready_r <= 1'b1;
            end else begin
              state_r <= APB_WAIT;
            end
          end
        end
        APB_WAIT: begin
          if (!PSEL) begin
            state_r <= APB_IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (to_access_s) begin
              state_r <= APB_ACCESS;
              ready_r <= 1'b1;
            end
          end
        end
        APB_ACCESS: begin
          if (!PSEL || PENABLE) begin
            state_r <= APB_IDLE;
            ready_r <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= APB_IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  apb_reg_bank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .we     (we_s),
    .widx   (idx_r),
    .wdata  (wdata_r),
    .re     (re_s),
    .ridx   (ridx_s),
    .rdata  (rdata_s)
  );

  // Out-of-range reads are captured as a miss and present zero.
  assign PRDATA = rdata_s & {DATA_WIDTH{rd_hit_r}};
  assign PREADY = ready_r;

endmodule
